// File: rtl/fact_out_arbiter_pkg.sv
// fact_pkg: shared constants for the result output path (state encoding, FIFO and result widths)
package fact_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WR_LO = 2'd1;
  localparam logic [1:0] WR_HI = 2'd2;
  localparam int DEF_FIFO_DEPTH = 32;
  localparam int CNT_W = 6;
  localparam int RES_W = 64;
endpackage

// File: rtl/fact_out_arbiter_if.sv
// fact_out_arbiter_if: core request/result/grant/done bundle plus output FIFO write port; master = arbiter side
interface fact_out_arbiter_if #(parameter int N_REQ = 4);
  import fact_pkg::*;
  logic [N_REQ-1:0] req;
  logic [RES_W*N_REQ-1:0] result;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic [CNT_W-1:0] fifo_data_count;
  logic fifo_wr_err;
  logic fifo_wr_en;
  logic [31:0] fifo_din;
  modport master (
    input req, result, fifo_data_count, fifo_wr_err,
    output grant, done, fifo_wr_en, fifo_din
  );
  modport slave (
    output req, result, fifo_data_count, fifo_wr_err,
    input grant, done, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/fact_out_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set req bit at or above ptr (mod N) wins; ports req/ptr in, onehot/idx/valid out
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] j;
  // scan from the farthest candidate back to ptr so the nearest one overwrites
  always_comb begin
    onehot = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        onehot = '0;
        onehot[j] = 1'b1;
        idx = j;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/fact_out_arbiter.sv
// fact_out_arbiter: round-robin arbiter writing each core's 64-bit result as two FIFO words (low first); ports clk/reset/clr_err, bus (master), busy/err/xfer_count
module fact_out_arbiter
  import fact_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_err,
  fact_out_arbiter_if.master  bus,
  output logic                busy,
  output logic                err,
  output logic [15:0]         xfer_count
);
  localparam int IW = $clog2(N_REQ);
  logic [1:0] state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, pick_idx;
  logic [RES_W-1:0] lat_q, lat_d, pick_res;
  logic [N_REQ-1:0] pick_oh, grant_q, grant_d, done_q, done_d;
  logic pick_v, start;
  logic wr_en_q, wr_en_d, busy_q, busy_d, err_q, err_d;
  logic [31:0] din_q, din_d;
  logic [15:0] cnt_q, cnt_d;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req(bus.req),
    .ptr(ptr_q),
    .onehot(pick_oh),
    .idx(pick_idx),
    .valid(pick_v)
  );
  assign pick_res = bus.result[pick_idx*RES_W +: RES_W];
  // both words must fit before starting, so a result is never split
  assign start = state_q == IDLE && pick_v && int'(bus.fifo_data_count) <= FIFO_DEPTH - 2;
  always_comb begin
    state_d = start ? WR_LO : (state_q == WR_LO ? WR_HI : IDLE);
    ptr_d = start ? (int'(pick_idx) == N_REQ - 1 ? '0 : pick_idx + 1'b1) : ptr_q;
    lat_d = start ? pick_res : lat_q;
    grant_d = start ? pick_oh : (state_q == WR_LO ? grant_q : '0);
    done_d = state_q == WR_LO ? grant_q : '0;
    wr_en_d = start || state_q == WR_LO;
    din_d = start ? pick_res[31:0] : (state_q == WR_LO ? lat_q[63:32] : '0);
    busy_d = state_d != IDLE;
    err_d = bus.fifo_wr_err || (err_q && !clr_err);
    cnt_d = cnt_q + 16'(state_q == WR_LO);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      lat_q <= '0;
      grant_q <= '0;
      done_q <= '0;
      wr_en_q <= 1'b0;
      din_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      lat_q <= lat_d;
      grant_q <= grant_d;
      done_q <= done_d;
      wr_en_q <= wr_en_d;
      din_q <= din_d;
      busy_q <= busy_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.grant = grant_q;
  assign bus.done = done_q;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_din = din_q;
  assign busy = busy_q;
  assign err = err_q;
  assign xfer_count = cnt_q;
endmodule

// File: tb/tb_fact_out_arbiter.sv
// tb_fact_out_arbiter: directed and random stimulus checked against a transfer-level reference model
module tb_fact_out_arbiter;
  import fact_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset, clr_err, busy, err;
  logic [15:0] xfer_count;
  int checks = 0;
  int errors = 0;
  int m_phase, m_ptr, m_win;
  logic [63:0] m_data;
  logic m_err;
  logic [15:0] m_cnt;
  fact_out_arbiter_if #(.N_REQ(N)) bus ();
  fact_out_arbiter #(.N_REQ(N), .FIFO_DEPTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .clr_err(clr_err),
    .bus(bus),
    .busy(busy),
    .err(err),
    .xfer_count(xfer_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // phase 0 = waiting, 1 = low word out, 2 = high word out
  task automatic model_step();
    bit found;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_win = 0; m_data = '0; m_err = 1'b0; m_cnt = '0;
      return;
    end
    m_err = bus.fifo_wr_err || (m_err && !clr_err);
    if (m_phase == 1) begin
      m_phase = 2;
      m_cnt = m_cnt + 16'd1;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (bus.req != 0 && int'(bus.fifo_data_count) <= 30) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && bus.req[(m_ptr + k) % N]) begin
          found = 1;
          m_win = (m_ptr + k) % N;
        end
      end
      m_data = bus.result[m_win*64 +: 64];
      m_ptr = (m_win + 1) % N;
      m_phase = 1;
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("wr_en", bus.fifo_wr_en, m_phase != 0);
    chk("din", bus.fifo_din, m_phase == 1 ? m_data[31:0] : (m_phase == 2 ? m_data[63:32] : 32'h0));
    chk("grant", bus.grant, m_phase != 0 ? (64'd1 << m_win) : 64'd0);
    chk("done", bus.done, m_phase == 2 ? (64'd1 << m_win) : 64'd0);
    chk("busy", busy, m_phase != 0);
    chk("err", err, m_err);
    chk("xfer_count", xfer_count, m_cnt);
  endtask
  initial begin
    reset = 1'b1; clr_err = 1'b0;
    bus.req = '0; bus.result = '0; bus.fifo_data_count = '0; bus.fifo_wr_err = 1'b0;
    m_phase = 0; m_ptr = 0; m_win = 0; m_data = '0; m_err = 1'b0; m_cnt = '0;
    tick();
    tick();
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_ptr", dut.ptr_q, 0);
    reset = 1'b0;
    bus.result[127:64] = 64'h0000_0005_0000_0078;
    bus.req = 4'b0010;
    tick();
    chk("single_lo", bus.fifo_din, 32'h0000_0078);
    tick();
    chk("single_hi", bus.fifo_din, 32'h0000_0005);
    chk("single_done", bus.done, 4'b0010);
    chk("single_cnt", xfer_count, 16'd1);
    bus.req = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) bus.result[i*64 +: 64] = {$urandom, $urandom};
    bus.req = 4'hF;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("rr_grant", bus.grant, 64'd1 << (t % 4));
      tick();
      chk("rr_done", bus.done, 64'd1 << (t % 4));
      tick();
    end
    bus.req = '0;
    tick();
    bus.req = 4'b0100;
    bus.fifo_data_count = 6'd31;
    repeat (10) begin
      tick();
      chk("full31_no_wr", bus.fifo_wr_en, 1'b0);
    end
    bus.fifo_data_count = 6'd32;
    tick();
    chk("full32_no_wr", bus.fifo_wr_en, 1'b0);
    bus.fifo_data_count = 6'd30;
    tick();
    chk("space30_start", bus.fifo_wr_en, 1'b1);
    chk("space30_grant", bus.grant, 4'b0100);
    bus.req = '0;
    tick();
    chk("drop_done", bus.done, 4'b0100);
    chk("drop_hi_word", bus.fifo_din, bus.result[191:160]);
    tick();
    bus.fifo_data_count = '0;
    bus.req = 4'b1000;
    tick();
    tick();
    chk("pre_rst_done", bus.done, 4'b1000);
    reset = 1'b1;
    tick();
    chk("rst_hi_state", dut.state_q, IDLE);
    chk("rst_hi_ptr", dut.ptr_q, 0);
    chk("rst_hi_done", bus.done, 0);
    chk("rst_hi_wr_en", bus.fifo_wr_en, 0);
    reset = 1'b0;
    bus.req = '0;
    tick();
    bus.fifo_wr_err = 1'b1;
    tick();
    chk("err_set", err, 1'b1);
    bus.fifo_wr_err = 1'b0;
    bus.req = 4'b0001;
    tick();
    tick();
    tick();
    chk("err_sticky", err, 1'b1);
    bus.req = '0;
    clr_err = 1'b1;
    tick();
    chk("err_clr", err, 1'b0);
    bus.fifo_wr_err = 1'b1;
    tick();
    chk("err_prio", err, 1'b1);
    clr_err = 1'b0;
    bus.fifo_wr_err = 1'b0;
    tick();
    repeat (600) begin
      bus.req = N'($urandom);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) bus.result[i*64 +: 64] = {$urandom, $urandom};
      bus.fifo_data_count = 6'($urandom_range(26, 32));
      bus.fifo_wr_err = $urandom_range(0, 15) == 0;
      clr_err = $urandom_range(0, 7) == 0;
      reset = $urandom_range(0, 99) == 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
